// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state type and size constants for the FFT stage sequencer.
package fft_pkg;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam int FFT_N        = 8;
   localparam int FFT_LOG2N    = $clog2(FFT_N);
   localparam int FFT_HALF_N   = FFT_N / 2;
   localparam int FFT_TW_WIDTH = FFT_LOG2N - 1;
   localparam int DRAIN_EXTRA  = 2;

   // Drain spans the butterfly pipe plus RAM read and feeder register stages.
   function automatic int drain_len(input int lat);
      return lat + DRAIN_EXTRA;
   endfunction

endpackage

// File: rtl/addr_delay_line.sv
// addr_delay_line: fixed-depth shift register, DEPTH=0 is a plain wire.
module addr_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_pass
      assign q = d;
   end else begin : g_sr
      logic [WIDTH-1:0] r_sr [DEPTH];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
         end else begin
            r_sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
         end
      end
      assign q = r_sr[DEPTH-1];
   end

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: drives RAM reads, feeder, twiddle ROM and write-back for an in-place DIT FFT.
module fft_stage_sequencer import fft_pkg::*; #(
   parameter int N_POINTS   = FFT_N,
   parameter int LOG2N      = $clog2(N_POINTS),
   parameter int BF_LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr,
   output logic             feed_en,
   output logic             feed_sel,
   output logic [LOG2N-2:0] tw_addr,
   output logic [LOG2N-1:0] stage,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr0,
   output logic [LOG2N-1:0] wr_addr1
);

   localparam int HALF_N = N_POINTS / 2;
   localparam int BW     = LOG2N - 1;
   localparam int TW     = LOG2N - 1;
   localparam int DL     = drain_len(BF_LATENCY);
   localparam int CW     = $clog2(DL);

   function automatic logic [LOG2N-1:0] addr0(input logic [BW-1:0] bi, input logic [LOG2N-1:0] s);
      logic [LOG2N-1:0] bb;
      logic [LOG2N-1:0] m;
      bb = {1'b0, bi};
      m  = (LOG2N'(1) << s) - LOG2N'(1);
      return ((bb >> s) << (s + LOG2N'(1))) | (bb & m);
   endfunction

   function automatic logic [TW-1:0] twk(input logic [BW-1:0] bi, input logic [LOG2N-1:0] s);
      logic [LOG2N-1:0] j;
      j = {1'b0, bi} & ((LOG2N'(1) << s) - LOG2N'(1));
      return TW'(j << (LOG2N'(LOG2N-1) - s));
   endfunction

   state_t           r_state;
   logic [BW-1:0]    r_b;
   logic             r_phase;
   logic [LOG2N-1:0] r_stage;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_rd_en;
   logic [LOG2N-1:0] r_rd_addr;
   logic             r_wr_en;
   logic [LOG2N-1:0] r_wa0;
   logic [LOG2N-1:0] r_wa1;
   logic [TW-1:0]    r_tw;

   logic [LOG2N-1:0] w_a0;
   logic [LOG2N-1:0] w_a1;
   logic [TW-1:0]    w_k;
   logic             w_inj;
   logic             w_wv;
   logic [LOG2N-1:0] w_wa0;
   logic [LOG2N-1:0] w_wa1;
   logic             w_kv;
   logic [TW-1:0]    w_kq;

   assign w_a0  = addr0(r_b, r_stage);
   assign w_a1  = w_a0 + (LOG2N'(1) << r_stage);
   assign w_k   = twk(r_b, r_stage);
   assign w_inj = r_rd_en & ~r_phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_b       <= '0;
         r_phase   <= 1'b0;
         r_stage   <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_state   <= S_READ;
               r_stage   <= '0;
               r_b       <= '0;
               r_phase   <= 1'b0;
               r_busy    <= 1'b1;
               r_rd_en   <= 1'b1;
               r_rd_addr <= '0;
            end
            S_READ: begin
               r_phase <= ~r_phase;
               if (!r_phase) begin
                  r_rd_addr <= w_a1;
               end else if (r_b == BW'(HALF_N-1)) begin
                  r_state <= S_DRAIN;
                  r_rd_en <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_b       <= r_b + BW'(1);
                  r_rd_addr <= addr0(r_b + BW'(1), r_stage);
               end
            end
            S_DRAIN: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(DL-1)) begin
                  if (r_stage == LOG2N'(LOG2N-1)) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= S_READ;
                     r_stage   <= r_stage + LOG2N'(1);
                     r_b       <= '0;
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= '0;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Pair addresses enter on the x0 read; the output register adds the final cycle.
   addr_delay_line #(.WIDTH(1 + 2*LOG2N), .DEPTH(BF_LATENCY + 1)) u_wr_dly (
      .clk (clk),
      .rst (rst),
      .d   ({w_inj, w_a0, w_a1}),
      .q   ({w_wv, w_wa0, w_wa1})
   );

   addr_delay_line #(.WIDTH(2), .DEPTH(1)) u_feed_dly (
      .clk (clk),
      .rst (rst),
      .d   ({r_rd_en, r_phase}),
      .q   ({feed_en, feed_sel})
   );

   addr_delay_line #(.WIDTH(1 + TW), .DEPTH(1)) u_tw_dly (
      .clk (clk),
      .rst (rst),
      .d   ({w_inj, w_k}),
      .q   ({w_kv, w_kq})
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_en <= 1'b0;
         r_wa0   <= '0;
         r_wa1   <= '0;
         r_tw    <= '0;
      end else begin
         r_wr_en <= w_wv;
         if (w_wv) begin
            r_wa0 <= w_wa0;
            r_wa1 <= w_wa1;
         end
         if (w_kv) r_tw <= w_kq;
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign rd_en    = r_rd_en;
   assign rd_addr  = r_rd_addr;
   assign stage    = r_stage;
   assign tw_addr  = r_tw;
   assign wr_en    = r_wr_en;
   assign wr_addr0 = r_wa0;
   assign wr_addr1 = r_wa1;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed vectors for N=8/L=2 plus a RAM-order scoreboard for N=16/L=4.
module tb_fft_stage_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start_b = 1'b0;

   logic       busy, done, rd_en, feed_en, feed_sel, wr_en;
   logic [2:0] rd_addr, stage, wr_addr0, wr_addr1;
   logic [1:0] tw_addr;

   logic       busy_b, done_b, rd_en_b, feed_en_b, feed_sel_b, wr_en_b;
   logic [3:0] rd_addr_b, stage_b, wr_addr0_b, wr_addr1_b;
   logic [2:0] tw_addr_b;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   fft_stage_sequencer #(.N_POINTS(8), .LOG2N(3), .BF_LATENCY(2)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .feed_en(feed_en), .feed_sel(feed_sel),
      .tw_addr(tw_addr), .stage(stage), .wr_en(wr_en),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
   );

   fft_stage_sequencer #(.N_POINTS(16), .LOG2N(4), .BF_LATENCY(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .feed_en(feed_en_b), .feed_sel(feed_sel_b),
      .tw_addr(tw_addr_b), .stage(stage_b), .wr_en(wr_en_b),
      .wr_addr0(wr_addr0_b), .wr_addr1(wr_addr1_b)
   );

   typedef struct {
      logic       busy, done, rd_en;
      logic [2:0] rd_addr;
      logic       fe, fs;
      logic [1:0] tw;
      logic [2:0] stg;
      logic       we;
      logic [2:0] wa0, wa1;
   } vec_t;

   typedef struct {
      logic [3:0] a0, a1, s;
   } pair_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      start_b = 1'b0;
      repeat (3) step();
      rst = 1'b0;
   endtask

   function automatic logic [19:0] pack(input vec_t v);
      return {v.busy, v.done, v.rd_en, v.rd_addr, v.fe, v.fs, v.tw, v.stg, v.we, v.wa0, v.wa1};
   endfunction

   initial begin
      vec_t  vt [39];
      int    rd_t [3][8];
      int    tw_t [3][4];
      int    lrd, ltw, lwa0, lwa1, wcnt, bad, ph, done_cyc, ndone;
      int    rdcnt [16];
      int    pend [16];
      pair_t wq [$];
      pair_t tq [$];
      pair_t pr;
      logic [3:0] cur0;

      rd_t = '{'{0,1,2,3,4,5,6,7}, '{0,2,1,3,4,6,5,7}, '{0,4,1,5,2,6,3,7}};
      tw_t = '{'{0,0,0,0}, '{0,2,0,2}, '{0,1,2,3}};

      lrd = 0; ltw = 0; lwa0 = 0; lwa1 = 0;
      for (int c = 0; c < 39; c++) begin
         vt[c] = '{default: '0};
         vt[c].busy = (c >= 1 && c <= 36);
         vt[c].done = (c == 37);
         vt[c].stg  = (c <= 12) ? 3'd0 : (c <= 24) ? 3'd1 : 3'd2;
         for (int s = 0; s < 3; s++) begin
            int base;
            base = 1 + 12*s;
            if (c >= base && c <= base + 7) begin
               vt[c].rd_en = 1'b1;
               lrd = rd_t[s][c-base];
            end
            if (c >= base + 1 && c <= base + 8) begin
               vt[c].fe = 1'b1;
               vt[c].fs = ((c - base - 1) % 2 == 1);
            end
            if (c >= base + 2 && c <= base + 8 && (c - base - 2) % 2 == 0)
               ltw = tw_t[s][(c-base-2)/2];
            if (c >= base + 4 && c <= base + 10 && (c - base - 4) % 2 == 0) begin
               vt[c].we = 1'b1;
               lwa0 = rd_t[s][c-base-4];
               lwa1 = rd_t[s][c-base-3];
            end
         end
         vt[c].rd_addr = 3'(lrd);
         vt[c].tw      = 2'(ltw);
         vt[c].wa0     = 3'(lwa0);
         vt[c].wa1     = 3'(lwa1);
      end

      // Single transform, cycle-by-cycle against the table
      do_reset();
      for (int c = 0; c < 39; c++) begin
         start = (c == 0);
         chk($sformatf("vec c=%0d", c),
             32'({busy, done, rd_en, rd_addr, feed_en, feed_sel, tw_addr, stage, wr_en, wr_addr0, wr_addr1}),
             32'(pack(vt[c])));
         step();
      end

      // start held high: one restart from IDLE, none while busy
      do_reset();
      for (int c = 0; c < 78; c++) begin
         start = (c < 50);
         chk($sformatf("held busy/done c=%0d", c), {30'd0, busy, done},
             {30'd0, (c >= 1 && c <= 36) || (c >= 39 && c <= 74), (c == 37 || c == 75)});
         if (c == 38) chk("held idle rd_en", 32'(rd_en), 32'd0);
         if (c == 39) chk("held restart rd", 32'({rd_en, rd_addr, stage}), 32'({1'b1, 3'd0, 3'd0}));
         step();
      end
      start = 1'b0;

      // Reset in the middle of stage 1 read
      do_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (14) step();
      chk("midrst pre stage/rd_en", 32'({stage, rd_en}), 32'({3'd1, 1'b1}));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst after", 32'({busy, rd_en, wr_en, done, stage}), 32'd0);
      wcnt = 0; bad = 0;
      for (int c = 0; c < 40; c++) begin
         if (wr_en) wcnt++;
         if (busy || rd_en || done) bad++;
         step();
      end
      chk("midrst no writes", 32'(wcnt), 32'd0);
      chk("midrst stays idle", 32'(bad), 32'd0);

      // N=16, BF_LATENCY=4 scoreboard: pairing, twiddles, hazards, latency
      do_reset();
      for (int a = 0; a < 16; a++) begin
         rdcnt[a] = 0;
         pend[a] = 0;
      end
      wcnt = 0; ph = 0; done_cyc = -1; ndone = 0; cur0 = '0;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int c = 1; c < 130; c++) begin
         if (rd_en_b) begin
            chk($sformatf("hazard c=%0d a=%0d", c, rd_addr_b), 32'(pend[rd_addr_b]), 32'd0);
            pend[rd_addr_b] = 1;
            rdcnt[rd_addr_b]++;
            if (ph == 0) begin
               cur0 = rd_addr_b;
            end else begin
               chk($sformatf("stride c=%0d", c), 32'(int'(rd_addr_b) - int'(cur0)), 32'(1 << stage_b));
               pr.a0 = cur0;
               pr.a1 = rd_addr_b;
               pr.s  = stage_b;
               wq.push_back(pr);
               tq.push_back(pr);
            end
            ph = 1 - ph;
         end
         if (feed_en_b && feed_sel_b) begin
            if (tq.size() == 0) begin
               chk("tw without pair", 32'd1, 32'd0);
            end else begin
               int hm, kexp;
               pr = tq.pop_front();
               hm = (1 << pr.s) - 1;
               kexp = ((int'(pr.a0) & hm) << (3 - int'(pr.s))) & 7;
               chk($sformatf("tw c=%0d", c), 32'(tw_addr_b), 32'(kexp));
            end
         end
         if (wr_en_b) begin
            wcnt++;
            if (wq.size() == 0) begin
               chk("write without pair", 32'd1, 32'd0);
            end else begin
               pr = wq.pop_front();
               chk($sformatf("wr addr c=%0d", c), 32'({wr_addr0_b, wr_addr1_b}), 32'({pr.a0, pr.a1}));
               pend[pr.a0] = 0;
               pend[pr.a1] = 0;
            end
         end
         if (done_b) begin
            ndone++;
            done_cyc = c;
         end
         step();
      end
      chk("b write count", 32'(wcnt), 32'd32);
      chk("b done cycle", 32'(done_cyc), 32'd89);
      chk("b done pulses", 32'(ndone), 32'd1);
      bad = 0;
      for (int a = 0; a < 16; a++) if (rdcnt[a] != 4) bad++;
      chk("b reads per address", 32'(bad), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
